alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter BITS, default 64, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 req_valid  input  [0:1]  per-requester request valid; index 0 = requester 0.
REQ-005 req_ready  output  [0:1]  per-requester request accepted this cycle.
REQ-006 req_a0, req_b0, req_a1, req_b1  input  [0:BITS-1] each  operands per requester; bit 0 = MSB.
REQ-007 req_op0, req_op1  input  [0:1] each  ALU control per requester: 00 add, 01 sub, 10 and, 11 or.
REQ-008 rsp_valid  output  [0:1]  per-requester response valid.
REQ-009 rsp_ready  input  [0:1]  per-requester response accepted.
REQ-010 rsp_result  output  [0:BITS-1]  shared response data, qualified by rsp_valid.
REQ-011 rsp_flags  output  [0:3]  shared response flags: [0] overflow, [1] carry, [2] negative, [3] zero.
REQ-012 alu_srca, alu_srcb  output  [0:BITS-1]  operands driven to the external combinational ALU.
REQ-013 alu_ctrl  output  [0:1]  control driven to the ALU.
REQ-014 alu_result  input  [0:BITS-1]; alu_flags  input  [0:3]  ALU outputs, valid same cycle as inputs.

Function
REQ-015 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-016 IDLE: if any req_valid, grant one requester, assert its req_ready combinationally, latch its a/b/op into operand registers, go EXEC; else stay IDLE.
REQ-017 Grant rule: single valid requester wins; both valid -> requester not granted last wins; after reset requester 0 has priority.
REQ-018 req_ready is never asserted outside IDLE and never for more than one requester.
REQ-019 EXEC lasts exactly one cycle: alu_srca/alu_srcb/alu_ctrl driven from operand registers; alu_result/alu_flags captured into response registers at end of cycle; go RESP.
REQ-020 RESP: rsp_valid asserted only for granted requester; rsp_result/rsp_flags held stable until rsp_ready for that requester is high; then update last-grant register and go IDLE.
REQ-021 rsp_ready of the non-granted requester is ignored.
REQ-022 Latency: accept at cycle N -> rsp_valid at N+2; back-to-back throughput one op per 3 cycles with rsp_ready held high.
REQ-023 alu_srca/alu_srcb/alu_ctrl hold operand-register values in all states (no combinational path from req_* to alu_*).
REQ-024 A requester may drop req_valid before acceptance without effect; operands change after acceptance without effect.

Reset
REQ-025 rst_n low at a clock edge: state -> IDLE, last-grant -> requester 1 (so requester 0 has priority), operand and response registers -> 0.
REQ-026 During and after reset: req_ready = 00, rsp_valid = 00, rsp_result = 0, rsp_flags = 0000, alu_ctrl = 00.
REQ-027 Reset in EXEC or RESP discards the in-flight operation; no response is issued for it.

Structure
REQ-028 Shared package alu_pkg holds: ALU op encodings (ADD, SUB, AND, OR), flag bit indices (V, C, N, Z), FSM state enum.
REQ-029 Grant logic in one sub-module rr_arb2 (inputs valid[0:1], last-grant; output one-hot grant); all other logic inline.

Verification
REQ-030 Reset, then idle 5 cycles -> req_ready=00, rsp_valid=00, rsp_result=0, flags=0000.
REQ-031 Requester 0 add 5+3, rsp_ready high -> req_ready[0] at N, rsp_valid[0] at N+2, result 8, flags 0000.
REQ-032 Both valid every cycle, rsp_ready=11: req0 sub 3-3, req1 or 0xF0|0x0F -> grants 0,1,0,1...; req0 result 0 flags zero=1, carry=1; req1 result 0xFF.
REQ-033 Requester 1 add 0x7FFF_FFFF_FFFF_FFFF+1, rsp_ready low 4 cycles -> rsp_valid[1] held, result 0x8000_0000_0000_0000, overflow=1, negative=1, stable until rsp_ready.
REQ-034 rst_n low during RESP of an op -> next cycle rsp_valid=00, state IDLE, requester 0 wins next simultaneous request.
REQ-035 Requester 0 changes req_a0 the cycle after acceptance -> result reflects latched value only.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op encodings,
// flag bit positions and the control FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_t;

    // Flag positions within the [0:3] flag vector (index 0 is the MSB).
    localparam int FLAG_V    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_Z    = 3;
    localparam int NUM_FLAGS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on contention
// the requester that was not granted last wins.
module rr_arb2 (
    input  logic [0:1] valid,
    input  logic       last,
    output logic [0:1] grant
);

    assign grant[0] = valid[0] & (~valid[1] | last);
    assign grant[1] = valid[1] & (~valid[0] | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU; each
// operation runs IDLE (accept) -> EXEC (drive ALU) -> RESP (hold result).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [0:1]           req_valid,
    output logic [0:1]           req_ready,
    input  logic [0:BITS-1]      req_a0,
    input  logic [0:BITS-1]      req_b0,
    input  logic [0:BITS-1]      req_a1,
    input  logic [0:BITS-1]      req_b1,
    input  logic [0:1]           req_op0,
    input  logic [0:1]           req_op1,
    output logic [0:1]           rsp_valid,
    input  logic [0:1]           rsp_ready,
    output logic [0:BITS-1]      rsp_result,
    output logic [0:NUM_FLAGS-1] rsp_flags,
    output logic [0:BITS-1]      alu_srca,
    output logic [0:BITS-1]      alu_srcb,
    output logic [0:1]           alu_ctrl,
    input  logic [0:BITS-1]      alu_result,
    input  logic [0:NUM_FLAGS-1] alu_flags
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   last_grant;   // index of requester served last
    logic                   owner;        // index of requester in flight
    logic [0:1]             grant;
    logic                   accept;
    logic                   rsp_done;
    logic [0:BITS-1]        op_a;
    logic [0:BITS-1]        op_b;
    alu_op_t                op_ctrl;
    logic [0:BITS-1]        res_result;
    logic [0:NUM_FLAGS-1]   res_flags;

    rr_arb2 u_arb (
        .valid (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign accept   = (state == ST_IDLE) && (|req_valid);
    assign rsp_done = (state == ST_RESP) && rsp_ready[owner];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; reset is synchronous, so it sits inside the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)   state_nxt = ST_EXEC;
            ST_EXEC:               state_nxt = ST_RESP;
            ST_RESP: if (rsp_done) state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held so nothing
    // looks accepted before the first reset edge settles the FSM.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (rst_n) begin
            if (state == ST_IDLE) req_ready = grant;
            if (state == ST_RESP) rsp_valid[owner] = 1'b1;
        end
    end

    // NOTE: data registers are reset too, so alu_ctrl and the response
    // bus read as zero after reset rather than carrying a stale operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= OP_ADD;
            res_result <= '0;
            res_flags  <= '0;
        end else begin
            if (accept) begin
                owner   <= grant[1];
                op_a    <= grant[1] ? req_a1 : req_a0;
                op_b    <= grant[1] ? req_b1 : req_b0;
                op_ctrl <= alu_op_t'(grant[1] ? req_op1 : req_op0);
            end
            if (state == ST_EXEC) begin
                res_result <= alu_result;
                res_flags  <= alu_flags;
            end
            if (rsp_done) last_grant <= owner;
        end
    end

    assign alu_srca   = op_a;
    assign alu_srcb   = op_b;
    assign alu_ctrl   = op_ctrl;
    assign rsp_result = res_result;
    assign rsp_flags  = res_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-requester operations plus
// hand-written arbitration, backpressure, reset and operand-latching sequences.
module tb_alu_arbiter;

    localparam int BITS = 64;

    logic            clk;
    logic            rst_n;
    logic [0:1]      req_valid;
    logic [0:1]      req_ready;
    logic [0:BITS-1] req_a0, req_b0, req_a1, req_b1;
    logic [0:1]      req_op0, req_op1;
    logic [0:1]      rsp_valid;
    logic [0:1]      rsp_ready;
    logic [0:BITS-1] rsp_result;
    logic [0:3]      rsp_flags;
    logic [0:BITS-1] alu_srca, alu_srcb;
    logic [0:1]      alu_ctrl;
    logic [0:BITS-1] alu_result;
    logic [0:3]      alu_flags;

    int n_vec = 0;
    int n_bad = 0;

    alu_arbiter #(.BITS(BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU: add/sub with carry = no-borrow, V/N/Z.
    logic [63:0] m_a, m_b, m_r;
    logic [64:0] m_s;
    logic        m_c, m_v;
    always_comb begin
        m_a = alu_srca;
        m_b = alu_srcb;
        m_s = '0;
        m_r = '0;
        m_c = 1'b0;
        m_v = 1'b0;
        case (alu_ctrl)
            2'b00: begin
                m_s = {1'b0, m_a} + {1'b0, m_b};
                m_r = m_s[63:0];
                m_c = m_s[64];
                m_v = (m_a[63] == m_b[63]) && (m_r[63] != m_a[63]);
            end
            2'b01: begin
                m_s = {1'b0, m_a} + {1'b0, ~m_b} + 65'd1;
                m_r = m_s[63:0];
                m_c = m_s[64];
                m_v = (m_a[63] != m_b[63]) && (m_r[63] != m_a[63]);
            end
            2'b10:   m_r = m_a & m_b;
            default: m_r = m_a | m_b;
        endcase
        alu_result = m_r;
        alu_flags  = {m_v, m_c, m_r[63], (m_r == 64'd0)};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input int who, input logic [1:0] op,
                             input logic [63:0] a, input logic [63:0] b);
        if (who == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op;
        end
        req_valid[who] = 1'b1;
    endtask

    // Leaves the bench at a falling edge with reset released and the DUT idle.
    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          who;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  flg;   // {V, C, N, Z}
    } vec_t;

    // Entered at a falling edge with the DUT idle; leaves it idle again.
    task automatic run_vec(input vec_t v);
        logic [0:1] oh;
        oh = 2'b00;
        oh[v.who] = 1'b1;
        rsp_ready = 2'b11;
        drive_req(v.who, v.op, v.a, v.b);
        #1 check("vec accept", req_ready, oh);
        @(negedge clk);
        req_valid = 2'b00;
        #1 check("vec exec rsp_valid", rsp_valid, 2'b00);
        check("vec exec alu_ctrl", alu_ctrl, v.op);
        @(negedge clk);
        #1 check("vec rsp_valid", rsp_valid, oh);
        check("vec result", rsp_result, v.res);
        check("vec flags", rsp_flags, v.flg);
        @(negedge clk);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 2'b00, 64'd5, 64'd3, 64'd8, 4'b0000};
        vecs[1] = '{1, 2'b01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010};
        vecs[2] = '{0, 2'b10, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000};
        vecs[3] = '{1, 2'b11, 64'd0, 64'd0, 64'd0, 4'b0001};
        vecs[4] = '{0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101};
        vecs[5] = '{0, 2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};

        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_op0 = 2'b00; req_op1 = 2'b00;

        // Reset held with requests pending: nothing may be accepted.
        @(negedge clk);
        @(negedge clk);
        #1 check("rst req_ready", req_ready, 2'b00);
        check("rst rsp_valid", rsp_valid, 2'b00);
        check("rst rsp_result", rsp_result, 64'd0);
        check("rst rsp_flags", rsp_flags, 4'b0000);
        check("rst alu_ctrl", alu_ctrl, 2'b00);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check("idle req_ready", req_ready, 2'b00);
            check("idle rsp_valid", rsp_valid, 2'b00);
        end
        check("idle rsp_result", rsp_result, 64'd0);
        check("idle rsp_flags", rsp_flags, 4'b0000);
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both requesters valid every cycle: grants alternate 0,1,0,1.
        reset_dut();
        req_a0 = 64'd3;  req_b0 = 64'd3;  req_op0 = 2'b01;
        req_a1 = 64'hF0; req_b1 = 64'h0F; req_op1 = 2'b11;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [0:1] oh;
            oh = 2'b00;
            oh[k % 2] = 1'b1;
            #1 check("rr accept", req_ready, oh);
            @(negedge clk);
            #1 check("rr exec req_ready", req_ready, 2'b00);
            check("rr exec rsp_valid", rsp_valid, 2'b00);
            @(negedge clk);
            #1 check("rr rsp_valid", rsp_valid, oh);
            check("rr result", rsp_result, (k % 2 == 0) ? 64'd0 : 64'hFF);
            check("rr flags", rsp_flags, (k % 2 == 0) ? 4'b0101 : 4'b0000);
            check("rr resp req_ready", req_ready, 2'b00);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Requester 1 overflow with its rsp_ready low; requester 0's ready is ignored.
        @(negedge clk);
        rsp_ready = 2'b10;
        drive_req(1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        #1 check("bp accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        req_a1    = 64'd0;
        #1 check("bp exec rsp_valid", rsp_valid, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("bp held rsp_valid", rsp_valid, 2'b01);
            check("bp held result", rsp_result, 64'h8000_0000_0000_0000);
            check("bp held flags", rsp_flags, 4'b1010);
        end
        @(negedge clk);
        rsp_ready = 2'b01;
        #1 check("bp release rsp_valid", rsp_valid, 2'b01);
        check("bp release result", rsp_result, 64'h8000_0000_0000_0000);
        @(negedge clk);
        #1 check("bp done rsp_valid", rsp_valid, 2'b00);

        // Complete a requester-0 op so last-grant points at 0, then reset mid-RESP.
        @(negedge clk);
        rsp_ready = 2'b11;
        drive_req(0, 2'b00, 64'd1, 64'd1);
        #1 check("pre accept", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1 check("pre result", rsp_result, 64'd2);
        @(negedge clk);
        rsp_ready = 2'b00;
        drive_req(0, 2'b00, 64'd6, 64'd7);
        #1 check("inflight accept", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1 check("inflight rsp_valid", rsp_valid, 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        #1 check("post-rst rsp_valid", rsp_valid, 2'b00);
        check("post-rst rsp_result", rsp_result, 64'd0);
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        drive_req(0, 2'b00, 64'd2, 64'd2);
        drive_req(1, 2'b11, 64'h1, 64'h2);
        #1 check("post-rst grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1 check("post-rst rsp_valid0", rsp_valid, 2'b10);
        check("post-rst result", rsp_result, 64'd4);
        @(negedge clk);

        // Operands changed right after acceptance must not leak into the op.
        @(negedge clk);
        rsp_ready = 2'b11;
        drive_req(0, 2'b00, 64'd10, 64'd20);
        #1 check("latch accept", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        req_a0    = 64'd100;
        #1 check("latch alu_srca", alu_srca, 64'd10);
        @(negedge clk);
        #1 check("latch rsp_valid", rsp_valid, 2'b10);
        check("latch result", rsp_result, 64'd30);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog expired");
    end

endmodule
